window_frame_sequencer: RTL and testbench

WINDOW_FRAME_SEQUENCER -- requirements
Module: window_frame_sequencer

---
 rtl/window_seq_pkg.sv | 16 +
 rtl/window_frame_sequencer_if.sv | 40 ++++
 rtl/win_out_fifo.sv | 81 ++++++++
 rtl/window_frame_sequencer.sv | 138 +++++++++++++
 tb/tb_window_frame_sequencer.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/window_seq_pkg.sv
// Shared types and constants for the window frame sequencer.
//
// Contents:
//    seqState_t  - sequencer states: IDLE, RUN, DRAIN
//    FIFO_DEPTH  - number of entries held by the output FIFO
package window_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } seqState_t;

   localparam int FIFO_DEPTH = 4;

endpackage

// File: rtl/window_frame_sequencer_if.sv
// Streaming bus around the window frame sequencer.
//
// Signals:
//    in_valid / in_sample / in_ready        - filtered-sample stream from the FIFO/low-pass stage
//    win_sample / win_index                 - sample and coefficient index to the windowing datapath
//    win_product                            - registered product returned by the datapath
//    out_valid / out_data / out_first /
//    out_last / out_ready                   - windowed-frame stream to the FFT
//
// Modports:
//    master - the sequencer side
//    slave  - the surrounding environment (source, datapath, FFT)
interface window_frame_sequencer_if #(
   parameter int W     = 16,
   parameter int IDX_W = 10
);

   logic             in_valid;
   logic [W-1:0]     in_sample;
   logic             in_ready;
   logic [W-1:0]     win_sample;
   logic [IDX_W-1:0] win_index;
   logic [2*W-1:0]   win_product;
   logic             out_valid;
   logic [2*W-1:0]   out_data;
   logic             out_first;
   logic             out_last;
   logic             out_ready;

   modport master (
      input  in_valid, in_sample, win_product, out_ready,
      output in_ready, win_sample, win_index, out_valid, out_data, out_first, out_last
   );

   modport slave (
      output in_valid, in_sample, win_product, out_ready,
      input  in_ready, win_sample, win_index, out_valid, out_data, out_first, out_last
   );

endinterface

// File: rtl/win_out_fifo.sv
// Small synchronous FIFO holding tagged windowed samples on their way to the FFT.
//
// Ports:
//    clk, reset  - rising-edge clock, synchronous active-high reset
//    i_push      - write i_data this cycle
//    i_data      - entry to write
//    i_pop       - discard the head entry this cycle
//    o_data      - head entry, forced to zero while empty
//    o_empty     - no entries held
//    o_count     - number of entries held
module win_out_fifo #(
   parameter int WIDTH = 34,
   parameter int DEPTH = 4,
   localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_empty,
   output logic [CW-1:0]    o_count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wrPtr;
   logic [PW-1:0]    r_rdPtr;
   logic [CW-1:0]    r_count;
   logic             w_full;
   logic             w_doPush;
   logic             w_doPop;

   // Pointers wrap explicitly so depths that are not a power of two also work.
   function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] ptr);
      return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
   endfunction

   assign o_empty  = (r_count == '0);
   assign w_full   = (r_count == CW'(DEPTH));
   assign w_doPush = i_push && !w_full;
   assign w_doPop  = i_pop && !o_empty;
   assign o_count  = r_count;

   // Zero while empty keeps the output quiet after reset; while an entry waits
   // at the head it cannot change because writes only land in free slots.
   assign o_data = o_empty ? '0 : r_mem[r_rdPtr];

   // Storage carries no reset; validity is tracked entirely by r_count.
   always_ff @(posedge clk) begin
      if (w_doPush) begin
         r_mem[r_wrPtr] <= i_data;
      end
   end

   // Pointer and occupancy bookkeeping; push and pop together leave the count alone.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_doPush) begin
            r_wrPtr <= nextPtr(r_wrPtr);
         end
         if (w_doPop) begin
            r_rdPtr <= nextPtr(r_rdPtr);
         end
         case ({w_doPush, w_doPop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // The sequencer's flow control guarantees room for every push.
   noOverflow: assert property (@(posedge clk) disable iff (reset) !(i_push && w_full));

endmodule

// File: rtl/window_frame_sequencer.sv
// Window frame sequencer: pulls filtered samples, steps the window coefficient
// index through frames of N samples, and forwards the windowed products to the
// FFT with first/last frame tags.
//
// Ports:
//    clk, reset     - rising-edge clock, synchronous active-high reset
//    i_start        - pulse that arms continuous framing
//    i_stop         - pulse that ends framing after the current frame
//    bus            - sample input, datapath and output streams (master side)
//    o_busy         - high whenever the sequencer is not idle
//    o_frame_count  - number of completed frames, wrapping at 16 bits
module window_frame_sequencer
   import window_seq_pkg::*;
#(
   parameter int W     = 16,
   parameter int N     = 1024,
   parameter int IDX_W = 10
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i_start,
   input  logic                    i_stop,
   window_frame_sequencer_if.master bus,
   output logic                    o_busy,
   output logic [15:0]             o_frame_count
);

   localparam int FW  = 2*W + 2;
   localparam int CW  = $clog2(FIFO_DEPTH + 1);
   localparam int CW1 = CW + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   seqState_t        r_state;
   logic [IDX_W-1:0] r_idx;
   logic             r_inflight;
   logic             r_tagFirst;
   logic             r_tagLast;
   logic             r_stopPending;
   logic [15:0]      r_frameCount;

   logic             w_inReady;
   logic             w_accept;
   logic             w_outValid;
   logic             w_pop;
   logic             w_fifoEmpty;
   logic [CW-1:0]    w_fifoCount;
   logic [FW-1:0]    w_fifoData;

   // Samples already in the FIFO plus the one whose product is still in the
   // datapath must never exceed the FIFO depth, so space is reserved up front.
   assign w_inReady = !reset && (r_state == RUN) &&
                      (({1'b0, w_fifoCount} + CW1'(r_inflight)) < CW1'(FIFO_DEPTH));
   assign w_accept  = bus.in_valid && w_inReady;

   // The datapath registers the product on the accept edge, so it needs the
   // sample and index combinationally in the same cycle.
   assign bus.in_ready   = w_inReady;
   assign bus.win_sample = bus.in_sample;
   assign bus.win_index  = r_idx;

   assign w_outValid    = !reset && !w_fifoEmpty;
   assign w_pop         = w_outValid && bus.out_ready;
   assign bus.out_valid = w_outValid;
   assign bus.out_data  = reset ? '0 : w_fifoData[2*W-1:0];
   assign bus.out_first = !reset && w_fifoData[FW-1];
   assign bus.out_last  = !reset && w_fifoData[FW-2];

   assign o_busy        = !reset && (r_state != IDLE);
   assign o_frame_count = r_frameCount;

   // Sequencer FSM: the index advances on every accepted sample, the tags ride
   // along one cycle behind to meet the product, and DRAIN waits until both the
   // datapath stage and the FIFO have emptied before going idle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= IDLE;
         r_idx         <= '0;
         r_inflight    <= 1'b0;
         r_tagFirst    <= 1'b0;
         r_tagLast     <= 1'b0;
         r_stopPending <= 1'b0;
         r_frameCount  <= '0;
      end else begin
         r_inflight <= w_accept;
         if (w_accept) begin
            r_tagFirst <= (r_idx == '0);
            r_tagLast  <= (r_idx == LAST_IDX);
         end
         unique case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_state       <= RUN;
                  r_idx         <= '0;
                  r_stopPending <= i_stop;
               end
            end
            RUN: begin
               if (i_stop) begin
                  r_stopPending <= 1'b1;
               end
               if (w_accept) begin
                  if (r_idx == LAST_IDX) begin
                     r_idx        <= '0;
                     r_frameCount <= r_frameCount + 16'd1;
                     if (r_stopPending || i_stop) begin
                        r_state <= DRAIN;
                     end
                  end else begin
                     r_idx <= r_idx + IDX_W'(1);
                  end
               end
            end
            DRAIN: begin
               if (!r_inflight && w_fifoEmpty) begin
                  r_state       <= IDLE;
                  r_stopPending <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   win_out_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_outFifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (r_inflight),
      .i_data  ({r_tagFirst, r_tagLast, bus.win_product}),
      .i_pop   (w_pop),
      .o_data  (w_fifoData),
      .o_empty (w_fifoEmpty),
      .o_count (w_fifoCount)
   );

endmodule

// File: tb/tb_window_frame_sequencer.sv
// Self-checking bench for window_frame_sequencer with N=8 and coeff[i]=i.
// A small datapath model registers sample*coeff[index]; a scoreboard queue
// receives the expected tagged product for every accepted sample and is
// compared against every beat the FFT side takes.
module tb_window_frame_sequencer;

   localparam int W     = 16;
   localparam int N     = 8;
   localparam int IDX_W = 3;
   localparam int PW    = 2*W;

   typedef struct {
      logic [PW-1:0] data;
      logic          first;
      logic          last;
   } expItem_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        stop;
   logic        busy;
   logic [15:0] frameCount;

   window_frame_sequencer_if #(.W(W), .IDX_W(IDX_W)) bus();

   window_frame_sequencer #(
      .W     (W),
      .N     (N),
      .IDX_W (IDX_W)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .i_start       (start),
      .i_stop        (stop),
      .bus           (bus),
      .o_busy        (busy),
      .o_frame_count (frameCount)
   );

   expItem_t sbQ[$];
   expItem_t popItem;
   int testsRun      = 0;
   int testsFailed   = 0;
   int expIdx        = 0;
   int expFrame      = 0;
   int expFrameCount = 0;
   int acceptCount   = 0;
   int popCount      = 0;
   int cycleNo       = 0;
   int firstPopCycle = 0;
   int lastPopCycle  = 0;

   // Free-running clock.
   always #5 clk = ~clk;

   // Windowing datapath model: one registered stage, coefficient equal to index.
   always @(posedge clk) begin
      bus.win_product <= PW'(bus.win_sample) * PW'(bus.win_index);
   end

   // Watchdog so a stuck design still ends the run.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog observed=still running expected=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [W-1:0] sampleFor(input int idx, input int frame);
      return W'(100 + idx + 10 * (frame % 32));
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Scoreboard monitor, sampled on the falling edge so both handshakes are settled.
   always @(negedge clk) begin
      cycleNo++;
      if (bus.out_valid && bus.out_ready) begin
         checkOutput("sbNotEmpty", 64'(sbQ.size() != 0), 64'd1);
         if (sbQ.size() != 0) begin
            popItem = sbQ.pop_front();
            checkOutput("beat", 64'({bus.out_first, bus.out_last, bus.out_data}),
                        64'({popItem.first, popItem.last, popItem.data}));
         end
         if (popCount == 0) firstPopCycle = cycleNo;
         lastPopCycle = cycleNo;
         popCount++;
      end
      if (bus.in_valid && bus.in_ready) begin
         sbQ.push_back('{data: PW'(bus.in_sample) * PW'(expIdx),
                         first: (expIdx == 0), last: (expIdx == N - 1)});
         acceptCount++;
         if (expIdx == N - 1) begin
            expIdx = 0;
            expFrame++;
            expFrameCount++;
         end else begin
            expIdx++;
         end
      end
   end

   // One cycle of stimulus; start/stop default low and are pulsed by the caller.
   task automatic applyStimulus(input int vPct, input int rPct);
      @(posedge clk);
      #1;
      start         = 1'b0;
      stop          = 1'b0;
      bus.in_valid  = ($urandom_range(99) < 32'(vPct));
      bus.in_sample = sampleFor(expIdx, expFrame);
      bus.out_ready = ($urandom_range(99) < 32'(rPct));
   endtask

   task automatic clearModel();
      sbQ.delete();
      expIdx        = 0;
      expFrame      = 0;
      expFrameCount = 0;
   endtask

   task automatic runUntilAccepts(input int target, input int vPct, input int rPct, input int budget);
      int n = 0;
      while (acceptCount < target && n < budget) begin
         applyStimulus(vPct, rPct);
         n++;
      end
      checkOutput("acceptsReached", 64'(acceptCount >= target), 64'd1);
   endtask

   task automatic waitIdle(input string tag, input int budget, input int vPct, input int rPct);
      int n = 0;
      do begin
         applyStimulus(vPct, rPct);
         n++;
      end while (busy === 1'b1 && n < budget);
      checkOutput(tag, 64'(busy), 64'd0);
   endtask

   // Directed sequence.
   initial begin
      int n;
      int acc0;
      logic sawDrain;

      reset         = 1'b1;
      start         = 1'b0;
      stop          = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_sample = 16'd7;
      bus.out_ready = 1'b1;

      // Reset state with the stream inputs asserted.
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rstBusy", 64'(busy), 64'd0);
      checkOutput("rstOutValid", 64'(bus.out_valid), 64'd0);
      checkOutput("rstInReady", 64'(bus.in_ready), 64'd0);
      checkOutput("rstOutBeat", 64'({bus.out_first, bus.out_last, bus.out_data}), 64'd0);
      checkOutput("rstFrameCount", 64'(frameCount), 64'd0);
      reset = 1'b0;
      clearModel();

      // Two back-to-back frames, stop during the second, no gaps.
      popCount = 0;
      acc0     = acceptCount;
      applyStimulus(100, 100);
      start = 1'b1;
      runUntilAccepts(acc0 + 12, 100, 100, 100);
      applyStimulus(100, 100);
      stop     = 1'b1;
      n        = 0;
      sawDrain = 1'b0;
      do begin
         applyStimulus(100, 100);
         n++;
         if (busy && !bus.in_ready && frameCount == 16'd2) sawDrain = 1'b1;
      end while (busy === 1'b1 && n < 200);
      checkOutput("contIdle", 64'(busy), 64'd0);
      checkOutput("contSawDrain", 64'(sawDrain), 64'd1);
      checkOutput("contPops", 64'(popCount), 64'd16);
      checkOutput("contNoGaps", 64'(lastPopCycle - firstPopCycle), 64'd15);
      checkOutput("contFrameCount", 64'(frameCount), 64'd2);
      checkOutput("contSbEmpty", 64'(sbQ.size()), 64'd0);

      // Backpressure: out_ready low for 10 cycles mid-frame.
      acc0 = acceptCount;
      applyStimulus(100, 100);
      start = 1'b1;
      runUntilAccepts(acc0 + 3, 100, 100, 100);
      for (int k = 0; k < 10; k++) begin
         applyStimulus(100, 0);
         #1;
         checkOutput("holdValid", 64'(bus.out_valid), 64'd1);
         if (sbQ.size() != 0) begin
            checkOutput("holdBeat", 64'({bus.out_first, bus.out_last, bus.out_data}),
                        64'({sbQ[0].first, sbQ[0].last, sbQ[0].data}));
         end
      end
      checkOutput("bpInReady", 64'(bus.in_ready), 64'd0);
      checkOutput("bpOutstanding", 64'(sbQ.size()), 64'd4);
      applyStimulus(100, 100);
      stop = 1'b1;
      waitIdle("bpIdle", 200, 100, 100);
      checkOutput("bpFrameCount", 64'(frameCount), 64'd3);
      checkOutput("bpSbEmpty", 64'(sbQ.size()), 64'd0);

      // Start and stop in the same idle cycle give exactly one frame.
      popCount = 0;
      applyStimulus(100, 100);
      start = 1'b1;
      stop  = 1'b1;
      waitIdle("oneShotIdle", 200, 100, 100);
      checkOutput("oneShotPops", 64'(popCount), 64'd8);
      checkOutput("oneShotFrameCount", 64'(frameCount), 64'd4);

      // Reset at idx 5 discards the partial frame.
      acc0 = acceptCount;
      applyStimulus(100, 100);
      start = 1'b1;
      runUntilAccepts(acc0 + 5, 100, 100, 100);
      applyStimulus(100, 100);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      clearModel();
      #1;
      checkOutput("midRstOutValid", 64'(bus.out_valid), 64'd0);
      checkOutput("midRstFrameCount", 64'(frameCount), 64'd0);
      checkOutput("midRstBusy", 64'(busy), 64'd0);
      repeat (3) applyStimulus(100, 100);
      checkOutput("noStartBusy", 64'(busy), 64'd0);
      checkOutput("noStartInReady", 64'(bus.in_ready), 64'd0);
      popCount = 0;
      applyStimulus(100, 100);
      start = 1'b1;
      applyStimulus(100, 100);
      stop = 1'b1;
      waitIdle("restartIdle", 200, 100, 100);
      checkOutput("restartPops", 64'(popCount), 64'd8);
      checkOutput("restartFrameCount", 64'(frameCount), 64'd1);

      // Random 50% valid/ready over 20 frames.
      applyStimulus(0, 100);
      reset = 1'b1;
      applyStimulus(0, 100);
      reset = 1'b0;
      clearModel();
      applyStimulus(50, 50);
      start = 1'b1;
      n = 0;
      while (expFrameCount < 19 && n < 6000) begin
         applyStimulus(50, 50);
         n++;
      end
      checkOutput("randProgress", 64'(expFrameCount >= 19), 64'd1);
      stop = 1'b1;
      waitIdle("randIdle", 800, 50, 50);
      checkOutput("randFrameCount", 64'(frameCount), 64'd20);
      checkOutput("randModelFrames", 64'(expFrameCount), 64'd20);
      checkOutput("randSbEmpty", 64'(sbQ.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
